// File: rtl/cdc_app_pkg.sv
// Shared constants for the CDC application-side stages: ASCII control
// characters and the line-echo state encoding.
package cdc_app_pkg;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    typedef logic [1:0] state_t;

    localparam state_t RX      = 2'd0;
    localparam state_t TX_LINE = 2'd1;
    localparam state_t TX_CR   = 2'd2;
    localparam state_t TX_LF   = 2'd3;

endpackage

// File: rtl/cdc_line_echo.sv
// Line-editing echo app for the usb_cdc FIFO interface: collects OUT bytes
// into a line with backspace editing, then echoes the line back followed by CR LF.
module cdc_line_echo
    import cdc_app_pkg::*;
#(
    parameter int LINE_LEN = 16,
    parameter int LINES_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         out_data_i,
    input  logic               out_valid_i,
    output logic               out_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [LINES_W-1:0] lines_o
);

    localparam int IW    = $clog2(LINE_LEN + 1);
    localparam int AW    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [IW-1:0]      IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]      IDX_FULL  = IW'(LINE_LEN);
    localparam logic [LINES_W-1:0] LINES_ONE = LINES_W'(1);

    state_t             state_reg, state_next;
    logic [IW-1:0]      count_reg, count_next;
    logic [IW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [LINES_W-1:0] lines_reg, lines_next;
    logic               overflow_reg, overflow_next;
    logic               wr_en;
    logic               accept;
    logic               xfer;

    logic [7:0] line_buf [DEPTH];

    assign out_ready_o = (state_reg == RX);
    assign busy_o      = (state_reg != RX);
    assign in_valid_o  = (state_reg != RX);
    assign overflow_o  = overflow_reg;
    assign lines_o     = lines_reg;

    assign accept = out_valid_i & out_ready_o;
    assign xfer   = in_valid_o & in_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= RX;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            lines_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            lines_reg    <= lines_next;
            overflow_reg <= overflow_next;
        end
    end

    // Line storage is deliberately left out of reset; count bounds what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            line_buf[count_reg[AW-1:0]] <= out_data_i;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        lines_next    = lines_reg;
        overflow_next = 1'b0;
        wr_en         = 1'b0;
        case (state_reg)
            RX: begin
                if (accept) begin
                    if (out_data_i == CR) begin
                        state_next = (count_reg != '0) ? TX_LINE : TX_CR;
                    end else if (out_data_i == BS || out_data_i == DEL) begin
                        if (count_reg != '0) begin
                            count_next = count_reg - IDX_ONE;
                        end
                    end else if (out_data_i != LF) begin
                        // The filling byte is kept and the line is force-terminated.
                        wr_en      = 1'b1;
                        count_next = count_reg + IDX_ONE;
                        if ((count_reg + IDX_ONE) == IDX_FULL) begin
                            overflow_next = 1'b1;
                            state_next    = TX_LINE;
                        end
                    end
                end
            end
            TX_LINE: begin
                if (xfer) begin
                    rd_ptr_next = rd_ptr_reg + IDX_ONE;
                    if (rd_ptr_reg == (count_reg - IDX_ONE)) begin
                        state_next = TX_CR;
                    end
                end
            end
            TX_CR: begin
                if (xfer) begin
                    state_next = TX_LF;
                end
            end
            TX_LF: begin
                if (xfer) begin
                    state_next  = RX;
                    count_next  = '0;
                    rd_ptr_next = '0;
                    lines_next  = lines_reg + LINES_ONE;
                end
            end
            default: begin
                state_next = RX;
            end
        endcase
    end

    always_comb begin
        in_data_o = 8'h00;
        case (state_reg)
            TX_LINE: in_data_o = line_buf[rd_ptr_reg[AW-1:0]];
            TX_CR:   in_data_o = CR;
            TX_LF:   in_data_o = LF;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cdc_line_echo.sv
// Self-checking bench for cdc_line_echo: queue-based line-editing model,
// per-cycle compare process, directed scenarios plus a randomized run.
`timescale 1ns/1ps
module tb_cdc_line_echo;

    localparam int LINE_LEN = 16;
    localparam int LINES_W  = 16;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [7:0]         out_data_i = 8'h00;
    logic               out_valid_i = 1'b0;
    logic               out_ready_o;
    logic [7:0]         in_data_o;
    logic               in_valid_o;
    logic               in_ready_i;
    logic               busy_o;
    logic               overflow_o;
    logic [LINES_W-1:0] lines_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] line_q[$];
    logic [7:0] echo_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         exp_lines   = 0;
    logic       ovf_pending = 1'b0;
    logic       stall_prev  = 1'b0;
    logic [7:0] data_prev   = 8'h00;
    logic       acc_seen    = 1'b0;
    int         vcyc        = 0;
    int         ovf_cnt     = 0;
    int         rdy_mode    = 0;

    cdc_line_echo #(.LINE_LEN(LINE_LEN), .LINES_W(LINES_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .out_data_i (out_data_i),
        .out_valid_i(out_valid_i),
        .out_ready_o(out_ready_o),
        .in_data_o  (in_data_o),
        .in_valid_o (in_valid_o),
        .in_ready_i (in_ready_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o),
        .lines_o    (lines_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Reference model: a line is a queue; termination appends it plus CR LF to the echo queue.
    function automatic void flush_line();
        foreach (line_q[i]) echo_q.push_back(line_q[i]);
        echo_q.push_back(8'h0D);
        echo_q.push_back(8'h0A);
        line_q.delete();
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (b == 8'h0D) begin
            flush_line();
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
        end else if (b != 8'h0A) begin
            line_q.push_back(b);
            if (line_q.size() == LINE_LEN) begin
                flush_line();
                ovf_pending = 1'b1;
            end
        end
    endfunction

    // Compare process: mid-cycle, checks outputs against the model, then
    // applies the handshakes that will complete on the coming edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            line_q.delete();
            echo_q.delete();
            exp_lines   = 0;
            ovf_pending = 1'b0;
            stall_prev  = 1'b0;
            acc_seen    = 1'b0;
        end else begin
            chk("busy", busy_o, echo_q.size() != 0);
            chk("out_ready", out_ready_o, echo_q.size() == 0);
            chk("in_valid", in_valid_o, echo_q.size() != 0);
            chk("lines", lines_o, exp_lines % (1 << LINES_W));
            chk("overflow", overflow_o, ovf_pending);
            ovf_pending = 1'b0;
            if (overflow_o) ovf_cnt++;
            if (stall_prev) chk("stable_data", in_data_o, data_prev);
            if (!in_valid_o) chk("idle_data", in_data_o, 8'h00);
            stall_prev = in_valid_o & ~in_ready_i;
            data_prev  = in_data_o;
            if (in_valid_o) vcyc++;
            if (in_valid_o && in_ready_i) begin
                got_q.push_back(in_data_o);
                if (echo_q.size() == 0) begin
                    fail("unexpected_byte", $sformatf("got %02h want no transfer", in_data_o));
                end else begin
                    exp_b = echo_q.pop_front();
                    chk("echo_byte", in_data_o, exp_b);
                    if (exp_b == 8'h0A) begin
                        exp_lines++;
                        $display("line %0d echoed", exp_lines);
                    end
                end
            end
            acc_seen = out_valid_i & out_ready_o;
            if (acc_seen) model_accept(out_data_i);
        end
    end

    // in_ready_i driver: 0 = always ready, 1 = ~30% stalls, 2 = never ready.
    initial begin
        in_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            case (rdy_mode)
                0:       in_ready_i = 1'b1;
                1:       in_ready_i = ($urandom_range(99) >= 30);
                default: in_ready_i = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        out_valid_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0;
        got_q.delete();
        vcyc    = 0;
        ovf_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_seen && n < 3000);
        if (!acc_seen) fail("send_timeout", $sformatf("byte %02h got no handshake want one within 3000 cycles", b));
        out_valid_i = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((echo_q.size() != 0 || busy_o) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail("idle_timeout", "got busy want idle within 3000 cycles");
        repeat (2) tick();
    endtask

    task automatic chk_got(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) chk(name, got_q[i], exp[i]);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: got no finish want finish before 900us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [7:0] b;

        // Reset values
        do_reset();
        @(negedge clk_i);
        chk("rst_out_ready", out_ready_o, 1);
        chk("rst_in_valid", in_valid_o, 0);
        chk("rst_in_data", in_data_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_lines", lines_o, 0);
        chk("rst_overflow", overflow_o, 0);
        tick();

        // "abc" CR
        rdy_mode = 0;
        exp_q = {8'h61, 8'h62, 8'h63, 8'h0D};
        send_q(exp_q);
        wait_idle();
        exp_q = {8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
        chk_got("t1_echo", exp_q);
        chk("t1_lines", lines_o, 1);
        chk("t1_valid_cycles", vcyc, 5);
        $display("test abc_cr done");

        // Backspace editing and a trailing host LF
        do_reset();
        exp_q = {8'h61, 8'h62, 8'h08, 8'h63, 8'h0D, 8'h0A};
        send_q(exp_q);
        wait_idle();
        exp_q = {8'h61, 8'h63, 8'h0D, 8'h0A};
        chk_got("t2_echo", exp_q);
        chk("t2_lines", lines_o, 1);
        $display("test backspace done");

        // Buffer full forces termination
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h30 + i));
        send_q(exp_q);
        wait_idle();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        chk_got("t3_echo", exp_q);
        chk("t3_overflows", ovf_cnt, 1);
        chk("t3_lines", lines_o, 1);
        $display("test overflow done");

        // Empty line, then backspace on an empty buffer
        do_reset();
        exp_q = {8'h0D, 8'h08, 8'h0D};
        send_q(exp_q);
        wait_idle();
        exp_q = {8'h0D, 8'h0A, 8'h0D, 8'h0A};
        chk_got("t4_echo", exp_q);
        chk("t4_lines", lines_o, 2);
        $display("test empty_line done");

        // Random stalls on the IN side
        do_reset();
        rdy_mode = 1;
        exp_q = {8'h78, 8'h79, 8'h7A, 8'h0D};
        send_q(exp_q);
        wait_idle();
        rdy_mode = 0;
        exp_q = {8'h78, 8'h79, 8'h7A, 8'h0D, 8'h0A};
        chk_got("t5_echo", exp_q);
        $display("test stalls done");

        // Reset in the middle of an echo
        do_reset();
        rdy_mode = 2;
        exp_q = {8'h68, 8'h69, 8'h0D};
        send_q(exp_q);
        n = 0;
        while (!in_valid_o && n < 100) begin
            tick();
            n++;
        end
        if (!in_valid_o) fail("t6_wait_valid", "got no in_valid want in_valid within 100 cycles");
        rdy_mode = 0;
        tick();
        rst_i    = 1'b1;
        rdy_mode = 2;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6_in_valid_after_rst", in_valid_o, 0);
        chk("t6_lines_after_rst", lines_o, 0);
        chk("t6_partial_len", got_q.size(), 1);
        if (got_q.size() > 0) chk("t6_partial_byte", got_q[0], 8'h68);
        tick();
        got_q.delete();
        rdy_mode = 0;
        exp_q = {8'h71, 8'h0D};
        send_q(exp_q);
        wait_idle();
        exp_q = {8'h71, 8'h0D, 8'h0A};
        chk_got("t6_echo", exp_q);
        chk("t6_lines", lines_o, 1);
        $display("test mid_tx_reset done");

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if (k % 20 == 0) rdy_mode = $urandom_range(1);
            r = $urandom_range(99);
            if (r < 8)       b = 8'h0D;
            else if (r < 12) b = 8'h08;
            else if (r < 14) b = 8'h7F;
            else if (r < 17) b = 8'h0A;
            else if (r < 20) b = 8'($urandom_range(31));
            else             b = 8'($urandom_range(8'h7E, 8'h20));
            send_byte(b);
            repeat ($urandom_range(2)) tick();
        end
        send_byte(8'h0D);
        wait_idle();
        rdy_mode = 0;
        chk("rand_lines_final", lines_o, exp_lines % (1 << LINES_W));
        chk("rand_echo_drained", echo_q.size(), 0);
        $display("test random done, lines=%0d overflows=%0d", exp_lines, ovf_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_line_echo.md
Name: cdc_line_echo

Overview:
- Application-side stage that connects directly to the usb_cdc application FIFO interface.
- Consumes OUT bytes (host→device) from usb_cdc out_data_o/out_valid_o/out_ready_i.
- Assembles bytes into a line buffer with backspace editing.
- On CR or buffer full, echoes the line back through usb_cdc in_data_i/in_valid_i/in_ready_o, terminated by CR LF.
- Serves as the board-level bring-up and loopback app for the CDC core.

Parameters:
- LINE_LEN, 16: line buffer depth in bytes; must be ≥2. Index width is clog2(LINE_LEN+1).
- LINES_W, 16: width of the completed-line counter.

Ports:
- clk_i, input, 1: single clock. Same domain as usb_cdc app side (app_clk_i when USE_APP_CLK=1, else clk_i).
- rst_i, input, 1: reset, synchronous and active-high.
- out_data_i, input, 8: byte from usb_cdc out_data_o.
- out_valid_i, input, 1: from usb_cdc out_valid_o.
- out_ready_o, output, 1: to usb_cdc out_ready_i. A byte is consumed when out_valid_i & out_ready_o.
- in_data_o, output, 8: to usb_cdc in_data_i.
- in_valid_o, output, 1: to usb_cdc in_valid_i.
- in_ready_i, input, 1: from usb_cdc in_ready_o. A byte is transferred when in_valid_o & in_ready_i.
- busy_o, output, 1: high while echoing; out_ready_o is low during this time.
- overflow_o, output, 1: one-cycle pulse when a line is force-terminated by a full buffer.
- lines_o, output, LINES_W: count of completed echoes; wraps modulo 2^LINES_W.

Behaviour:
- States: RX, TX_LINE, TX_CR, TX_LF. State, count, rd_ptr and lines_o are registered.
- Reset values:
  - state=RX, count=0, rd_ptr=0, lines_o=0, overflow_o=0.
  - out_ready_o=1 from the first cycle after reset.
  - in_valid_o=0, in_data_o=0x00, busy_o=0.
  - Buffer contents are not reset.
- out_ready_o is 1 only in RX. busy_o = (state != RX). Both are decoded from the registered state.
- in_valid_o is 1 only in TX_*. in_data_o is defined by state:
  - TX_LINE: buf[rd_ptr]
  - TX_CR: 0x0D
  - TX_LF: 0x0A
  - RX: 0x00
- in_data_o is stable while in_valid_o=1 and in_ready_i=0.
- RX, on an accepted byte b:
  - b=0x0D: go to TX_LINE if count>0, else TX_CR (an empty line echoes only CR LF).
  - b=0x08 or 0x7F: count decrements if count>0; otherwise ignored. Nothing is echoed.
  - b=0x0A: ignored (a host CRLF yields one line).
  - Otherwise: buf[count]<=b and count increments. If the new count==LINE_LEN, pulse overflow_o (registered, high the next cycle) and go to TX_LINE.
- TX_LINE:
  - On each transfer, rd_ptr increments.
  - A transfer with rd_ptr==count-1 goes to TX_CR.
- TX_CR: a transfer goes to TX_LF.
- TX_LF, on a transfer:
  - go to RX; count<=0, rd_ptr<=0
  - lines_o increments, wrapping to 0 after all-ones
- Latency:
  - The first echo byte is valid on the cycle after the terminating byte is accepted.
  - With in_ready_i held at 1, an N-byte line completes in exactly N+2 cycles of in_valid_o.
  - out_ready_o returns to 1 on the cycle after LF is transferred.
- Stalls: in_ready_i may deassert at any cycle. The state machine holds with no byte skipped or duplicated.
- OUT bytes arriving while busy stay pending in usb_cdc; none are dropped.
- rst_i asserted mid-TX: the echo is abandoned and in_valid_o=0 on the next cycle. The partial line is discarded and lines_o is cleared.
- The byte that fills the buffer is stored and echoed. The line is then terminated with CR LF.
- Out-of-scope byte values (0x00–0x1F other than those listed above) are stored and echoed verbatim.

Decomposition:
- Shared package cdc_app_pkg holds:
  - ASCII constants: CR=8'h0D, LF=8'h0A, BS=8'h08, DEL=8'h7F
  - state encoding (2-bit localparams RX/TX_LINE/TX_CR/TX_LF)
- Single module; the line buffer is an inferred register array, with no sub-module.

Test Plan:
- Send "abc",0x0D with in_ready_i=1 → in stream 0x61,0x62,0x63,0x0D,0x0A; lines_o=1; out_ready_o=0 during the 5 TX cycles.
- Send "ab",0x08,"c",0x0D,0x0A → echo "ac",CR,LF; the trailing 0x0A is absorbed; lines_o=1.
- Send 16 bytes 0x30..0x3F with LINE_LEN=16 → overflow_o pulses once; echo 0x30..0x3F,CR,LF without any CR sent.
- Send 0x0D into an empty buffer, then 0x08 into an empty buffer → echo CR,LF only; count remains 0.
- Send "xyz",0x0D with in_ready_i toggled in a random 30% pattern → exactly 0x78,0x79,0x7A,0x0D,0x0A; in_data_o stable whenever valid&!ready.
- Assert rst_i for 1 cycle during TX_LINE after 1 byte → in_valid_o=0 next cycle, lines_o=0; a subsequent "q",CR echoes "q",CR,LF.
